// File: rtl/pipe_delay_reg_if.sv
// ============================================================================
// Module   : pipe_delay_reg_if
// Brief    : Handshake bundle for pipe_delay_reg (upstream, downstream, flush).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_delay_reg_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_delay_reg.sv
// ============================================================================
// Module   : pipe_delay_reg
// Brief    : DEPTH-stage valid/ready delay pipeline with bubble collapsing,
//            synchronous flush and a registered occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_delay_reg #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_delay_reg_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;

    // A stage advances if out_ready or any stage at or after it is empty;
    // the running OR avoids a self-referencing chain on one vector.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry  = carry | ~valid_q[i];
            adv[i] = carry;
        end
    end

    assign bus.in_ready  = adv[0] & ~bus.flush;
    assign in_xfer       = bus.in_valid & bus.in_ready;
    assign out_xfer      = valid_q[DEPTH-1] & bus.out_ready;

    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.occupancy = occ_q;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (adv[0]) begin
            valid_d[0] = in_xfer;
            if (in_xfer) begin
                data_d[0] = bus.in_data;
            end
        end

        // Invalid entries move only their flag; data registers keep history.
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end

        if (bus.flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end
endmodule

`default_nettype wire

// File: doc/pipe_delay_reg.md
PIPE_DELAY_REG -- requirements
Module: pipe_delay_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 12, as the data width in bits (legal range 1..64).
REQ-002 The block SHALL take parameter DEPTH, default 4, as the number of pipeline stages (legal range 1..16).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 flush  input  1  synchronous clear of all in-flight entries.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  payload of the last stage.
REQ-012 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 The block SHALL hold DEPTH stages, each with a WIDTH-bit data register and a 1-bit valid flag; stage 0 is the input side and stage DEPTH-1 is the output side.
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Stage DEPTH-1 SHALL advance when its valid flag is 0 or out_ready is 1.
REQ-016 Stage i < DEPTH-1 SHALL advance when its valid flag is 0 or stage i+1 advances (bubble collapsing).
REQ-017 When a stage advances, it SHALL load data and valid from the stage before it; stage 0 loads in_data and the input-transfer flag.
REQ-018 When a stage advances but takes an invalid entry, its data register SHALL hold its previous value; only its valid flag changes.
REQ-019 in_ready SHALL equal (stage 0 advances) AND NOT flush, computed combinationally.
REQ-020 out_valid SHALL be the stage DEPTH-1 valid flag, and out_data SHALL be the stage DEPTH-1 data register, both driven directly from registers.
REQ-021 With out_ready held at 1, an entry accepted at edge N SHALL appear with out_valid=1 after edge N+DEPTH-1 (latency DEPTH cycles), and throughput SHALL be one entry per cycle.
REQ-022 When full with out_ready=0, in_ready SHALL be 0 and every stage SHALL hold its contents.
REQ-023 Simultaneous input and output transfer while full SHALL be sustained with no bubble and no loss.
REQ-024 When flush=1, every valid flag SHALL clear at the next edge, no input SHALL be accepted that cycle, and an output transfer in that cycle SHALL still count as delivered.
REQ-025 occupancy SHALL be a registered count that increments on an input-only transfer, decrements on an output-only transfer, and is unchanged when both or neither transfer occur.
REQ-026 occupancy SHALL go to 0 on flush and SHALL never exceed DEPTH.
REQ-027 Entries SHALL leave in strict acceptance order, and no entry SHALL be duplicated or dropped except by flush or rst.

Reset
REQ-028 While rst=1 at a rising edge, all valid flags, all data registers and occupancy SHALL become 0, so out_valid=0, out_data=0 and occupancy=0.
REQ-029 rst SHALL take priority over flush and over any transfer in the same cycle.
REQ-030 rst asserted mid-stream SHALL discard all in-flight entries.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Streaming, WIDTH=12, DEPTH=4: inputs 0x001..0x008 on consecutive cycles with out_ready=1 -> out_data equals 0x001 first, 4 cycles after the first accept, then 0x002..0x008 on consecutive cycles; occupancy holds at 4 in steady state.
REQ-033 Backpressure: with out_ready=0, feed 6 entries -> exactly 4 are accepted, in_ready=0, occupancy=4; raise out_ready -> outputs 1..6 in order with no gaps.
REQ-034 Bubble collapse: accept 0xAAA, hold out_ready=0, idle 3 cycles, accept 0xBBB -> 0xBBB lands directly behind 0xAAA and occupancy=2.
REQ-035 Flush: with 3 entries in flight, pulse flush with in_valid=1 -> that input is not accepted; next cycle occupancy=0 and out_valid=0.
REQ-036 Reset: assert rst while full and in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0, and in_ready=1 after rst drops.
REQ-037 Random regression: run random in_valid/out_ready for 10k cycles at DEPTH=1 and at DEPTH=16 against a scoreboard queue -> no order mismatch, no loss, and occupancy equals the queue length on every cycle.
